// File: rtl/instr_encoder_pkg.sv
// Shared ISA definitions for the instruction encoder and its decoder counterpart.
// Holds opcode constants, the encoder state type and the word-packing function.
package instr_encoder_pkg;

    localparam int unsigned WORD_W    = 9;
    localparam int unsigned OP_W      = 4;
    localparam int unsigned OPERAND_W = 8;

    localparam logic [OP_W-1:0] OP_DONE      = 4'd13;
    localparam logic [OP_W-1:0] OP_LOOKUP    = 4'd14;
    localparam logic [OP_W-1:0] OP_LOOKUP_BR = 4'd3;
    localparam logic [OP_W-1:0] OP_LOAD      = 4'd11;
    localparam logic [OP_W-1:0] OP_STORE     = 4'd12;
    localparam logic [OP_W-1:0] OP_REGWR     = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } enc_state_t;

    typedef struct packed {
        logic                 branch;
        logic [OP_W-1:0]      op;
        logic [OPERAND_W-1:0] operand;
    } instr_fields_t;

    // Branch words carry a full 8-bit target; others keep only operand[3:0].
    function automatic logic [WORD_W-1:0] encode_instr(
        input logic                 branch,
        input logic [OP_W-1:0]      op,
        input logic [OPERAND_W-1:0] operand
    );
        if (branch) begin
            return {1'b1, operand};
        end
        return {1'b0, op, operand[3:0]};
    endfunction

endpackage

// File: rtl/instr_encoder.sv
// Packs instruction field bundles into 9-bit words and streams them into
// instruction memory from address 0 until the done opcode or memory full.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_branch,
    input  logic [OP_W-1:0]      in_op,
    input  logic [OPERAND_W-1:0] in_operand,
    output logic                 wr_en,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [WORD_W-1:0]    wr_data,
    output logic [ADDR_W:0]      word_count,
    output logic                 load_done,
    output logic                 err_operand,
    output logic                 err_full
);

    localparam int unsigned       CNT_W     = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    enc_state_t          state;
    enc_state_t          state_next;
    logic [ADDR_W-1:0]   ptr;
    logic [ADDR_W-1:0]   ptr_next;
    logic                wr_en_next;
    logic [ADDR_W-1:0]   wr_addr_next;
    logic [WORD_W-1:0]   wr_data_next;
    logic [CNT_W-1:0]    word_count_next;
    logic                err_operand_next;
    logic                err_full_next;

    instr_fields_t fields;
    logic          accept;
    logic          is_done_op;
    logic          at_last;
    logic          restart;

    assign fields     = '{branch: in_branch, op: in_op, operand: in_operand};
    assign in_ready   = (state == RUN);
    assign accept     = in_valid && in_ready;
    assign is_done_op = !fields.branch && (fields.op == OP_DONE);
    assign at_last    = (ptr == LAST_ADDR);
    assign restart    = start && (state != RUN);

    // State and datapath registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= IDLE;
            ptr         <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            word_count  <= '0;
            load_done   <= 1'b0;
            err_operand <= 1'b0;
            err_full    <= 1'b0;
        end else begin
            state       <= state_next;
            ptr         <= ptr_next;
            wr_en       <= wr_en_next;
            wr_addr     <= wr_addr_next;
            wr_data     <= wr_data_next;
            word_count  <= word_count_next;
            load_done   <= (state_next == DONE);
            err_operand <= err_operand_next;
            err_full    <= err_full_next;
        end
    end

    // Next-state: a load ends on the done opcode or on the last address.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (accept && (is_done_op || at_last)) state_next = DONE;
            DONE:    if (start) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    // Write port, pointer and sticky error next values.
    always_comb begin
        ptr_next         = ptr;
        wr_en_next       = 1'b0;
        wr_addr_next     = wr_addr;
        wr_data_next     = wr_data;
        word_count_next  = word_count;
        err_operand_next = err_operand;
        err_full_next    = err_full;
        if (accept) begin
            wr_en_next      = 1'b1;
            wr_addr_next    = ptr;
            wr_data_next    = encode_instr(fields.branch, fields.op, fields.operand);
            word_count_next = word_count + CNT_W'(1);
            // Pointer saturates at the last word; the load ends there anyway.
            if (!at_last) begin
                ptr_next = ptr + ADDR_W'(1);
            end
            if (!fields.branch && (fields.operand[7:4] != 4'd0)) begin
                err_operand_next = 1'b1;
            end
            if (at_last && !is_done_op) begin
                err_full_next = 1'b1;
            end
        end else if (restart) begin
            ptr_next         = '0;
            word_count_next  = '0;
            err_operand_next = 1'b0;
            err_full_next    = 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder (ADDR_W=3): directed table, corner sequences and
// randomized traffic checked against a transaction-level model of the load.
module tb_instr_encoder;

    localparam int unsigned AW    = 3;
    localparam int          DEPTH = 1 << AW;

    logic          Clk;
    logic          Reset_n;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic          in_branch;
    logic [3:0]    in_op;
    logic [7:0]    in_operand;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [8:0]    wr_data;
    logic [AW:0]   word_count;
    logic          load_done;
    logic          err_operand;
    logic          err_full;

    instr_encoder #(.ADDR_W(AW)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_branch  (in_branch),
        .in_op      (in_op),
        .in_operand (in_operand),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .word_count (word_count),
        .load_done  (load_done),
        .err_operand(err_operand),
        .err_full   (err_full)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    // Model: 0 = idle, 1 = loading, 2 = finished.
    int m_mode, m_ptr, m_cnt;
    bit m_eop, m_efl;
    bit e_en;
    int e_addr, e_data;

    typedef struct {
        bit       s, v, b;
        bit [3:0] op;
        bit [7:0] opd;
        bit       rdy, en;
        int       addr, data, cnt;
        bit       dn, eop, efl;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_ptr = 0; m_cnt = 0; m_eop = 0; m_efl = 0;
    endtask

    // One clock of stimulus; model predicts the outputs seen after the edge.
    task automatic step(input bit s, input bit v, input bit b, input bit [3:0] op,
                        input bit [7:0] opd, input string tag);
        bit acc;
        start = s; in_valid = v; in_branch = b; in_op = op; in_operand = opd;
        chk({tag, ".in_ready"}, int'(in_ready), int'(m_mode == 1));
        acc  = v && (m_mode == 1);
        e_en = acc;
        if (acc) begin
            e_addr = m_ptr;
            e_data = b ? (256 + int'(opd)) : (int'(op) * 16 + int'(opd) % 16);
            m_cnt++;
            if (!b && opd >= 8'd16) m_eop = 1;
            if (!b && op == 4'd13) begin
                m_mode = 2;
            end else if (m_ptr == DEPTH - 1) begin
                m_mode = 2;
                m_efl  = 1;
            end else begin
                m_ptr++;
            end
        end else if (s && m_mode != 1) begin
            m_mode = 1; m_ptr = 0; m_cnt = 0; m_eop = 0; m_efl = 0;
        end
        @(posedge Clk);
        #1;
        chk({tag, ".wr_en"}, int'(wr_en), int'(e_en));
        if (e_en) begin
            chk({tag, ".wr_addr"}, int'(wr_addr), e_addr);
            chk({tag, ".wr_data"}, int'(wr_data), e_data);
        end
        chk({tag, ".word_count"}, int'(word_count), m_cnt);
        chk({tag, ".load_done"}, int'(load_done), int'(m_mode == 2));
        chk({tag, ".err_operand"}, int'(err_operand), int'(m_eop));
        chk({tag, ".err_full"}, int'(err_full), int'(m_efl));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //          s  v  b  op     opd    rdy en addr data     cnt dn eop efl
        tbl[0]  = '{1, 0, 0, 4'd0,  8'h00, 0,  0, 0, 0,       0,  0, 0,  0};
        tbl[1]  = '{0, 1, 0, 4'd4,  8'h05, 1,  1, 0, 'h045,   1,  0, 0,  0};
        tbl[2]  = '{0, 1, 1, 4'd0,  8'hA7, 1,  1, 1, 'h1A7,   2,  0, 0,  0};
        tbl[3]  = '{0, 1, 0, 4'd13, 8'h00, 1,  1, 2, 'h0D0,   3,  1, 0,  0};
        tbl[4]  = '{0, 1, 0, 4'd1,  8'h01, 0,  0, 0, 0,       3,  1, 0,  0};
        tbl[5]  = '{1, 0, 0, 4'd0,  8'h00, 0,  0, 0, 0,       0,  0, 0,  0};
        tbl[6]  = '{0, 1, 0, 4'd2,  8'h3C, 1,  1, 0, 'h02C,   1,  0, 1,  0};
        tbl[7]  = '{0, 1, 0, 4'd13, 8'h00, 1,  1, 1, 'h0D0,   2,  1, 1,  0};
        tbl[8]  = '{0, 0, 0, 4'd0,  8'h00, 0,  0, 0, 0,       2,  1, 1,  0};
        tbl[9]  = '{1, 0, 0, 4'd0,  8'h00, 0,  0, 0, 0,       0,  0, 0,  0};
        tbl[10] = '{0, 1, 1, 4'd0,  8'hD5, 1,  1, 0, 'h1D5,   1,  0, 0,  0};
        tbl[11] = '{1, 1, 0, 4'd1,  8'h02, 1,  1, 1, 'h012,   2,  0, 0,  0};

        Reset_n = 1'b0; start = 0; in_valid = 0; in_branch = 0; in_op = 0; in_operand = 0;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        chk("reset.in_ready", int'(in_ready), 0);
        chk("reset.wr_en", int'(wr_en), 0);
        chk("reset.wr_addr", int'(wr_addr), 0);
        chk("reset.wr_data", int'(wr_data), 0);
        chk("reset.word_count", int'(word_count), 0);
        chk("reset.load_done", int'(load_done), 0);
        chk("reset.errs", int'({err_operand, err_full}), 0);
        Reset_n = 1'b1;

        // Directed table: each row also checked against its literal expectations.
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("tbl%0d.rdy", i), int'(in_ready), int'(tbl[i].rdy));
            step(tbl[i].s, tbl[i].v, tbl[i].b, tbl[i].op, tbl[i].opd, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d.en", i), int'(wr_en), int'(tbl[i].en));
            if (tbl[i].en) begin
                chk($sformatf("tbl%0d.addr", i), int'(wr_addr), tbl[i].addr);
                chk($sformatf("tbl%0d.data", i), int'(wr_data), tbl[i].data);
            end
            chk($sformatf("tbl%0d.cnt", i), int'(word_count), tbl[i].cnt);
            chk($sformatf("tbl%0d.dn", i), int'(load_done), int'(tbl[i].dn));
            chk($sformatf("tbl%0d.eop", i), int'(err_operand), int'(tbl[i].eop));
            chk($sformatf("tbl%0d.efl", i), int'(err_full), int'(tbl[i].efl));
        end
        step(0, 1, 0, 4'd13, 8'h00, "tbl_end");

        // Fill memory with valid held high; no done opcode.
        step(1, 0, 0, 4'd0, 8'h00, "full.start");
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 1, 0, 4'd0, 8'(i), $sformatf("full%0d", i));
        end
        chk("full.err_full", int'(err_full), 1);
        chk("full.word_count", int'(word_count), DEPTH);
        chk("full.load_done", int'(load_done), 1);
        step(0, 1, 0, 4'd0, 8'h09, "full.extra");
        chk("full.extra_wr_en", int'(wr_en), 0);

        // Done opcode exactly at the last address: no full error.
        step(1, 0, 0, 4'd0, 8'h00, "lastdone.start");
        for (int i = 0; i < DEPTH - 1; i++) begin
            step(0, 1, 1, 4'd0, 8'(i), $sformatf("lastdone%0d", i));
        end
        step(0, 1, 0, 4'd13, 8'h00, "lastdone.end");
        chk("lastdone.err_full", int'(err_full), 0);
        chk("lastdone.load_done", int'(load_done), 1);

        // Stalled stream: valid toggles, six words written to 0..5.
        step(1, 0, 0, 4'd0, 8'h00, "stall.start");
        for (int i = 0; i < 12; i++) begin
            step(0, (i % 2) == 0, 0, 4'd5, 8'(i), $sformatf("stall%0d", i));
        end
        chk("stall.word_count", int'(word_count), 6);

        // Reset mid-load with an accept pending.
        step(1, 0, 0, 4'd0, 8'h00, "rst.start");
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 4'd7, 8'(i), $sformatf("rst%0d", i));
        end
        in_valid = 1'b1;
        #2;
        Reset_n = 1'b0;
        #1;
        chk("rst.async_wr_en", int'(wr_en), 0);
        chk("rst.async_word_count", int'(word_count), 0);
        chk("rst.async_in_ready", int'(in_ready), 0);
        chk("rst.async_load_done", int'(load_done), 0);
        @(posedge Clk);
        #1;
        chk("rst.held_wr_en", int'(wr_en), 0);
        Reset_n = 1'b1;
        model_reset();
        step(1, 0, 0, 4'd0, 8'h00, "rst.restart");
        step(0, 1, 0, 4'd6, 8'h03, "rst.first");
        chk("rst.first_addr", int'(wr_addr), 0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            bit       rs, rv, rb;
            bit [3:0] rop;
            bit [7:0] ropd;
            rs   = ($urandom_range(0, 7) == 0);
            rv   = ($urandom_range(0, 1) == 1);
            rb   = ($urandom_range(0, 3) == 0);
            rop  = ($urandom_range(0, 5) == 0) ? 4'd13 : 4'($urandom_range(0, 15));
            ropd = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15))
                                               : 8'($urandom_range(0, 255));
            step(rs, rv, rb, rop, ropd, $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
